// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: requester, page-flip and VRAM port bundle for vram_arbiter.
// slave = arbiter side, master = requesters plus VRAM macro side.
interface vram_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int OFS_W  = 14
);
    logic              vsync;

    logic              scan_req;
    logic [OFS_W-1:0]  scan_addr;
    logic              scan_ack;
    logic              scan_rvalid;
    logic [DATA_W-1:0] scan_rdata;

    logic              rast_req;
    logic [1:0]        rast_page;
    logic [OFS_W-1:0]  rast_addr;
    logic [DATA_W-1:0] rast_wdata;
    logic [3:0]        rast_wmask;
    logic              rast_ack;

    logic              cpy_req;
    logic              cpy_we;
    logic [OFS_W+1:0]  cpy_addr;
    logic [DATA_W-1:0] cpy_wdata;
    logic              cpy_ack;
    logic              cpy_rvalid;
    logic [DATA_W-1:0] cpy_rdata;

    logic              flip_req;
    logic [1:0]        flip_page;
    logic [1:0]        disp_page;
    logic              flip_done;

    logic              mem_en;
    logic              mem_we;
    logic [OFS_W+1:0]  mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        mem_wmask;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  vsync,
        input  scan_req, scan_addr,
        output scan_ack, scan_rvalid, scan_rdata,
        input  rast_req, rast_page, rast_addr, rast_wdata, rast_wmask,
        output rast_ack,
        input  cpy_req, cpy_we, cpy_addr, cpy_wdata,
        output cpy_ack, cpy_rvalid, cpy_rdata,
        input  flip_req, flip_page,
        output disp_page, flip_done,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_wmask,
        input  mem_rdata
    );

    modport master (
        output vsync,
        output scan_req, scan_addr,
        input  scan_ack, scan_rvalid, scan_rdata,
        output rast_req, rast_page, rast_addr, rast_wdata, rast_wmask,
        input  rast_ack,
        output cpy_req, cpy_we, cpy_addr, cpy_wdata,
        input  cpy_ack, cpy_rvalid, cpy_rdata,
        output flip_req, flip_page,
        input  disp_page, flip_done,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_wmask,
        output mem_rdata
    );
endinterface

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the single-port VRAM between scanout, rasterizer and
// copy engine, and commits display page flips on the vsync rising edge.
module vram_arbiter #(
    parameter int DATA_W = 16,
    parameter int OFS_W  = 14,
    parameter int RD_LAT = 2
) (
    input logic           clk,
    input logic           reset,
    vram_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_SCAN,
        SRC_RAST,
        SRC_CPY
    } src_e;

    src_e              win;
    src_e              rd_src;
    logic              rr_rast;
    logic              scan_ok;
    logic              rast_ok;
    logic              cpy_ok;
    logic              vsync_q;
    logic              pend_valid;
    logic [1:0]        pend_page;
    logic [RD_LAT-1:0] tag_scan;
    logic [RD_LAT-1:0] tag_cpy;
    logic [DATA_W-1:0] scan_hold;
    logic [DATA_W-1:0] cpy_hold;

    // Pick this cycle's winner; a requester being acked now sits out.
    always_comb begin
        scan_ok = bus.scan_req && !bus.scan_ack;
        rast_ok = bus.rast_req && !bus.rast_ack;
        cpy_ok  = bus.cpy_req && !bus.cpy_ack;
        win     = SRC_NONE;
        if (scan_ok)
            win = SRC_SCAN;
        else if (rast_ok && cpy_ok)
            win = rr_rast ? SRC_RAST : SRC_CPY;
        else if (rast_ok)
            win = SRC_RAST;
        else if (cpy_ok)
            win = SRC_CPY;
    end

    // Register acks and the VRAM command; idle cycles hold address/data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.scan_ack  <= 1'b0;
            bus.rast_ack  <= 1'b0;
            bus.cpy_ack   <= 1'b0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_wmask <= '0;
            rr_rast       <= 1'b1;
            rd_src        <= SRC_NONE;
        end else begin
            bus.scan_ack <= (win == SRC_SCAN);
            bus.rast_ack <= (win == SRC_RAST);
            bus.cpy_ack  <= (win == SRC_CPY);
            bus.mem_en   <= (win != SRC_NONE);
            // Only a contested rast/cpy cycle moves the pointer to the loser.
            if (rast_ok && cpy_ok && !scan_ok)
                rr_rast <= (win == SRC_CPY);
            rd_src <= SRC_NONE;
            unique case (win)
                SRC_SCAN: begin
                    bus.mem_we    <= 1'b0;
                    bus.mem_addr  <= {bus.disp_page, bus.scan_addr};
                    bus.mem_wmask <= 4'h0;
                    rd_src        <= SRC_SCAN;
                end
                SRC_RAST: begin
                    bus.mem_we    <= 1'b1;
                    bus.mem_addr  <= {bus.rast_page, bus.rast_addr};
                    bus.mem_wdata <= bus.rast_wdata;
                    bus.mem_wmask <= bus.rast_wmask;
                end
                SRC_CPY: begin
                    bus.mem_we    <= bus.cpy_we;
                    bus.mem_addr  <= bus.cpy_addr;
                    bus.mem_wdata <= bus.cpy_wdata;
                    bus.mem_wmask <= {4{bus.cpy_we}};
                    rd_src        <= bus.cpy_we ? SRC_NONE : SRC_CPY;
                end
                SRC_NONE: begin
                    bus.mem_we <= 1'b0;
                end
            endcase
        end
    end

    // Read tag pipeline: tag leaves the last stage RD_LAT cycles after mem_en.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_scan <= '0;
            tag_cpy  <= '0;
        end else begin
            tag_scan <= (tag_scan << 1) | RD_LAT'(rd_src == SRC_SCAN);
            tag_cpy  <= (tag_cpy << 1) | RD_LAT'(rd_src == SRC_CPY);
        end
    end

    // Keep the last returned word per requester for the non-valid cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_hold <= '0;
            cpy_hold  <= '0;
        end else begin
            if (tag_scan[RD_LAT-1])
                scan_hold <= bus.mem_rdata;
            if (tag_cpy[RD_LAT-1])
                cpy_hold <= bus.mem_rdata;
        end
    end

    // In the valid cycle rdata is the RAM port itself, so no extra latency.
    assign bus.scan_rvalid = tag_scan[RD_LAT-1];
    assign bus.cpy_rvalid  = tag_cpy[RD_LAT-1];
    assign bus.scan_rdata  = tag_scan[RD_LAT-1] ? bus.mem_rdata : scan_hold;
    assign bus.cpy_rdata   = tag_cpy[RD_LAT-1] ? bus.mem_rdata : cpy_hold;

    // Flip scheduler: commit the pending page on a vsync rise, last request wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vsync_q       <= 1'b0;
            pend_valid    <= 1'b0;
            pend_page     <= 2'd0;
            bus.disp_page <= 2'd0;
            bus.flip_done <= 1'b0;
        end else begin
            vsync_q       <= bus.vsync;
            bus.flip_done <= 1'b0;
            if (bus.vsync && !vsync_q && pend_valid) begin
                bus.disp_page <= pend_page;
                bus.flip_done <= 1'b1;
                pend_valid    <= 1'b0;
            end
            // A request on the edge cycle is kept for the following vsync.
            if (bus.flip_req) begin
                pend_page  <= bus.flip_page;
                pend_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: random requesters and flips against a queue-based model
// of the arbiter's grant, read-return and page-flip rules.
module tb_vram_arbiter;
    localparam int DW = 16;
    localparam int OW = 14;
    localparam int RL = 2;
    localparam int WAIT_MAX = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vram_arbiter_if #(.DATA_W(DW), .OFS_W(OW)) bus ();

    vram_arbiter #(.DATA_W(DW), .OFS_W(OW), .RD_LAT(RL)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        int          due;
        bit          scan;
        logic [15:0] addr;
    } rd_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    rd_t rq[$];
    rd_t mq[$];

    bit          e_sack, e_rack, e_cack, e_men, e_mwe, e_fdone, e_srv, e_crv;
    logic [15:0] e_maddr, e_mwdata, e_srd, e_crd;
    logic [3:0]  e_mwmask;
    logic [1:0]  e_disp, pend_p;
    bit          fav_rast, pend_v, vs_prev;

    bit s_busy, r_busy, c_busy;
    int s_wait, r_wait, c_wait;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] vram_word(input logic [15:0] a);
        return (a * 16'd40503) ^ {a[7:0], a[15:8]} ^ 16'h5A5A;
    endfunction

    task automatic model_reset();
        {e_sack, e_rack, e_cack, e_men, e_mwe, e_fdone, e_srv, e_crv} = '0;
        e_maddr = '0; e_mwdata = '0; e_srd = '0; e_crd = '0;
        e_mwmask = '0; e_disp = '0; pend_p = '0;
        fav_rast = 1'b1; pend_v = 1'b0; vs_prev = 1'b0;
        rq.delete();
        s_wait = 0; r_wait = 0; c_wait = 0;
    endtask

    // Expected outputs for the next cycle from the inputs seen this cycle.
    task automatic model_step();
        bit s_ok, r_ok, c_ok;
        int win;
        rd_t r;
        s_ok = bus.scan_req && !e_sack;
        r_ok = bus.rast_req && !e_rack;
        c_ok = bus.cpy_req && !e_cack;
        win = 0;
        if (s_ok) win = 1;
        else if (r_ok && c_ok) begin
            win = fav_rast ? 2 : 3;
            fav_rast = (win == 3);
        end
        else if (r_ok) win = 2;
        else if (c_ok) win = 3;
        e_sack = (win == 1);
        e_rack = (win == 2);
        e_cack = (win == 3);
        e_men = (win != 0);
        e_mwe = 1'b0;
        if (win == 1) begin
            e_maddr = {e_disp, bus.scan_addr};
            e_mwmask = 4'h0;
            rq.push_back('{cyc + 1 + RL, 1'b1, e_maddr});
        end else if (win == 2) begin
            e_maddr = {bus.rast_page, bus.rast_addr};
            e_mwe = 1'b1;
            e_mwdata = bus.rast_wdata;
            e_mwmask = bus.rast_wmask;
        end else if (win == 3) begin
            e_maddr = bus.cpy_addr;
            e_mwe = bus.cpy_we;
            e_mwdata = bus.cpy_wdata;
            e_mwmask = bus.cpy_we ? 4'hF : 4'h0;
            if (!bus.cpy_we) rq.push_back('{cyc + 1 + RL, 1'b0, e_maddr});
        end
        e_srv = 1'b0;
        e_crv = 1'b0;
        if (rq.size() > 0 && rq[0].due == cyc + 1) begin
            r = rq.pop_front();
            if (r.scan) begin e_srv = 1'b1; e_srd = vram_word(r.addr); end
            else begin e_crv = 1'b1; e_crd = vram_word(r.addr); end
        end
        e_fdone = 1'b0;
        if (bus.vsync && !vs_prev && pend_v) begin
            e_disp = pend_p;
            e_fdone = 1'b1;
            pend_v = 1'b0;
        end
        if (bus.flip_req) begin
            pend_p = bus.flip_page;
            pend_v = 1'b1;
        end
        vs_prev = bus.vsync;
    endtask

    task automatic compare();
        check("scan_ack", bus.scan_ack, e_sack);
        check("rast_ack", bus.rast_ack, e_rack);
        check("cpy_ack", bus.cpy_ack, e_cack);
        check("mem_en", bus.mem_en, e_men);
        check("mem_we", bus.mem_we, e_mwe);
        check("mem_addr", bus.mem_addr, e_maddr);
        check("mem_wmask", bus.mem_wmask, e_mwmask);
        if (e_men && e_mwe) check("mem_wdata", bus.mem_wdata, e_mwdata);
        check("disp_page", bus.disp_page, e_disp);
        check("flip_done", bus.flip_done, e_fdone);
        check("scan_rvalid", bus.scan_rvalid, e_srv);
        check("cpy_rvalid", bus.cpy_rvalid, e_crv);
        check("scan_rdata", bus.scan_rdata, e_srd);
        check("cpy_rdata", bus.cpy_rdata, e_crd);
    endtask

    // One clock: advance model, then VRAM model drives rdata, then compare.
    task automatic cycle(input bit in_reset);
        if (in_reset) model_reset();
        else model_step();
        @(posedge clk);
        #1;
        cyc++;
        while (mq.size() > 0 && mq[0].due < cyc) void'(mq.pop_front());
        if (mq.size() > 0 && mq[0].due == cyc) bus.mem_rdata = vram_word(mq.pop_front().addr);
        else bus.mem_rdata = 16'($urandom);
        if (bus.mem_en && !bus.mem_we) mq.push_back('{cyc + RL, 1'b0, bus.mem_addr});
        #1;
        compare();
    endtask

    // Requesters hold req/payload until acked, then may re-request at once.
    task automatic drive_reqs(input int ps, input int pr, input int pc, input bit fixed);
        if (s_busy && e_sack) begin check("scan_wait", 32'(s_wait <= WAIT_MAX), 1); s_busy = 0; end
        if (r_busy && e_rack) begin check("rast_wait", 32'(r_wait <= WAIT_MAX), 1); r_busy = 0; end
        if (c_busy && e_cack) begin check("cpy_wait", 32'(c_wait <= WAIT_MAX), 1); c_busy = 0; end
        if (s_busy) s_wait++;
        if (r_busy) r_wait++;
        if (c_busy) c_wait++;
        if (!s_busy && int'($urandom_range(99)) < ps) begin
            s_busy = 1; s_wait = 0;
            bus.scan_addr = 14'($urandom);
        end
        if (!r_busy && int'($urandom_range(99)) < pr) begin
            r_busy = 1; r_wait = 0;
            bus.rast_wdata = 16'($urandom);
            if (fixed) begin
                bus.rast_page = 2'd3; bus.rast_addr = 14'h0010; bus.rast_wmask = 4'b0101;
            end else begin
                bus.rast_page = 2'($urandom); bus.rast_addr = 14'($urandom);
                bus.rast_wmask = 4'($urandom);
            end
        end
        if (!c_busy && int'($urandom_range(99)) < pc) begin
            c_busy = 1; c_wait = 0;
            bus.cpy_wdata = 16'($urandom);
            if (fixed) begin
                bus.cpy_we = 1'b0; bus.cpy_addr = 16'h4123;
            end else begin
                bus.cpy_we = 1'($urandom); bus.cpy_addr = 16'($urandom);
            end
        end
        bus.scan_req = s_busy;
        bus.rast_req = r_busy;
        bus.cpy_req = c_busy;
    endtask

    task automatic step(input int ps, input int pr, input int pc, input bit fixed);
        drive_reqs(ps, pr, pc, fixed);
        cycle(1'b0);
    endtask

    task automatic steps(input int n, input int ps, input int pr, input int pc);
        for (int i = 0; i < n; i++) step(ps, pr, pc, 1'b0);
    endtask

    initial begin
        bus.vsync = 0; bus.flip_req = 0; bus.flip_page = 0; bus.mem_rdata = 0;
        bus.scan_addr = 14'h0123; bus.rast_page = 1; bus.rast_addr = 14'h0200;
        bus.rast_wdata = 16'h1234; bus.rast_wmask = 4'hF;
        bus.cpy_we = 0; bus.cpy_addr = 16'h8001; bus.cpy_wdata = 16'h5555;
        s_busy = 1; r_busy = 1; c_busy = 1;
        bus.scan_req = 1; bus.rast_req = 1; bus.cpy_req = 1;
        reset = 1;
        model_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1);
        reset = 0;

        step(100, 0, 0, 1'b0);
        check("first_grant_scan", bus.scan_ack, 1);
        steps(12, 0, 0, 0);

        for (int i = 0; i < 16; i++) step(0, 100, 100, 1'b1);
        steps(4, 0, 0, 0);
        for (int i = 0; i < 16; i++) step(100, 100, 0, 1'b0);
        steps(4, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 100, 1'b1);
        steps(4, 0, 0, 0);

        bus.flip_req = 1; bus.flip_page = 2;
        step(100, 0, 0, 1'b0);
        bus.flip_req = 0;
        steps(3, 100, 0, 0);
        bus.flip_req = 1; bus.flip_page = 1;
        step(100, 0, 0, 1'b0);
        bus.flip_req = 0;
        steps(3, 100, 0, 0);
        check("disp_before_vsync", bus.disp_page, 0);
        bus.vsync = 1;
        steps(3, 100, 0, 0);
        bus.vsync = 0;
        steps(6, 100, 0, 0);
        check("disp_after_flip", bus.disp_page, 1);

        steps(3, 0, 0, 0);
        bus.vsync = 1; bus.flip_req = 1; bus.flip_page = 3;
        step(0, 0, 0, 1'b0);
        bus.flip_req = 0;
        steps(3, 0, 0, 0);
        check("disp_coincident", bus.disp_page, 1);
        bus.vsync = 0;
        steps(4, 0, 0, 0);
        bus.vsync = 1;
        steps(3, 100, 0, 0);
        bus.vsync = 0;
        steps(3, 100, 0, 0);
        check("disp_next_vsync", bus.disp_page, 3);

        for (int blk = 0; blk < 6; blk++) begin
            int ps, pr, pc;
            ps = int'($urandom_range(100));
            pr = int'($urandom_range(100));
            pc = int'($urandom_range(100));
            for (int i = 0; i < 500; i++) begin
                bus.vsync = (cyc % 41) < 4;
                bus.flip_req = ($urandom_range(9) == 0);
                bus.flip_page = 2'($urandom);
                step(ps, pr, pc, 1'b0);
            end
        end

        bus.vsync = 0; bus.flip_req = 1; bus.flip_page = 2;
        step(100, 0, 100, 1'b1);
        bus.flip_req = 0;
        for (int i = 0; i < 20 && rq.size() < 2; i++) step(100, 0, 100, 1'b1);
        check("inflight_reads", 32'(rq.size() >= 2), 1);
        reset = 1;
        s_busy = 0; r_busy = 0; c_busy = 0;
        bus.scan_req = 0; bus.rast_req = 0; bus.cpy_req = 0;
        cycle(1'b1);
        cycle(1'b1);
        reset = 0;
        steps(3, 0, 0, 0);
        bus.vsync = 1;
        steps(3, 0, 0, 0);
        bus.vsync = 0;
        steps(4, 0, 0, 0);
        check("disp_after_reset", bus.disp_page, 0);

        for (int i = 0; i < 500; i++) begin
            bus.vsync = (cyc % 29) < 3;
            bus.flip_req = ($urandom_range(7) == 0);
            bus.flip_page = 2'($urandom);
            step(60, 60, 60, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares the single-port video RAM between three requesters: scanout reads, rasterizer writes and copy/fill engine reads/writes.
- Schedules page flips: the display page changes only on the vsync edge.
- Sits between the hvsync-driven scanout path, the polygon rasterizer and the VM page engine on one side, and the VRAM macro on the other.
- VRAM word = 4 pixels × 4 bpp; 4 pages of 320×200 map to {page[1:0], offset[13:0]}.

Parameters:
DATA_W, 16, VRAM word width (4 nibble pixels)
OFS_W, 14, word offset within a page
RD_LAT, 2, VRAM read latency in cycles from mem_en to mem_rdata valid (legal 1..4)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
vsync  in  1  vertical sync from hvsync generator, active-high
scan_req  in  1  scanout read request
scan_addr  in  OFS_W  word offset within display page
scan_ack  out  1  scanout request issued
scan_rvalid  out  1  scanout read data valid
scan_rdata  out  DATA_W  scanout read data
rast_req  in  1  rasterizer write request
rast_page  in  2  target page
rast_addr  in  OFS_W  word offset
rast_wdata  in  DATA_W  write data
rast_wmask  in  4  per-nibble write enable
rast_ack  out  1  rasterizer write issued
cpy_req  in  1  copy engine request
cpy_we  in  1  1=write (full word), 0=read
cpy_addr  in  OFS_W+2  full VRAM word address
cpy_wdata  in  DATA_W  write data
cpy_ack  out  1  copy request issued
cpy_rvalid  out  1  copy read data valid
cpy_rdata  out  DATA_W  copy read data
flip_req  in  1  single-cycle page flip request
flip_page  in  2  page to display
disp_page  out  2  currently displayed page
flip_done  out  1  one-cycle pulse when flip takes effect
mem_en, mem_we  out  1 each  VRAM access strobe / write enable
mem_addr  out  OFS_W+2  VRAM address
mem_wdata  out  DATA_W  VRAM write data
mem_wmask  out  4  VRAM nibble enables
mem_rdata  in  DATA_W  VRAM read data

Behaviour:
- Reset: all outputs 0. disp_page=0. No flip pending. Read tag pipeline cleared. Round-robin pointer favours rast.
- Handshake: requester holds req and payload stable until its ack.
  - ack is registered and pulses for exactly 1 cycle.
  - mem_* outputs are registered; they are driven in the same cycle as the ack.
  - Requester may drop or change req at the clock edge that ends the ack cycle.
- Eligibility: a requester whose ack is high this cycle is ineligible this cycle, preventing a double issue. Each requester therefore gets at most one access per 2 cycles.
- Priority: scan (eligible) always wins. Between rast and cpy, round-robin: the loser of a contested cycle wins the next contested one. An uncontested requester wins immediately.
- Address formation:
  - scan: {disp_page, scan_addr}, mem_we=0, mem_wmask=0.
  - rast: {rast_page, rast_addr}, mem_we=1, mem_wmask=rast_wmask.
  - cpy: cpy_addr, mem_we=cpy_we, mem_wmask=cpy_we?4'hF:0.
- Idle cycle: mem_en=0, mem_we=0, other mem_* hold their previous values.
- Read return:
  - Each issued read pushes a source tag (scan/cpy) into an RD_LAT-deep shift register.
  - Exactly RD_LAT cycles after the mem_en cycle, the matching rvalid pulses 1 cycle with rdata=mem_rdata. The other rdata holds its value.
  - Writes push a null tag. Reads return strictly in issue order.
- Page flip:
  - flip_req latches flip_page into pending and sets pending_valid. A later flip_req before vsync overwrites pending (last wins).
  - A vsync rising edge (registered vsync compare) with pending_valid sets disp_page<=pending, clears pending_valid and pulses flip_done.
  - A vsync edge with no pending flip does nothing.
  - flip_req in the same cycle as the vsync edge: the edge commits the old pending state; the new request stays pending for the next vsync.
  - A scan read already issued keeps its old page; disp_page affects only addresses issued after the change.
- Writes to the displayed page are permitted; no hazard checking.
- Reset mid-operation: in-flight reads are discarded (no rvalid after reset), pending flip is lost, disp_page returns to 0.

Test Plan:
- Reset with all req=1 -> all acks/mem_en=0 during reset. After release, first grant scan; disp_page=0; no rvalid for 10 cycles after the issue-free reset.
- rast_req+cpy_req held continuously, scan idle -> grants alternate rast, cpy, rast… one per cycle. rast_page=3, rast_addr=0x0010, rast_wmask=4'b0101 -> mem_addr=0xC010, mem_wmask=0101.
- scan_req held continuously with rast_req held -> scan acked every 2nd cycle; rast acked in the cycles between; rast never starves.
- cpy read at 0x4123, RD_LAT=2, memory model returning 0xBEEF -> cpy_rvalid exactly 2 cycles after mem_en, cpy_rdata=0xBEEF; scan_rvalid stays 0.
- flip_req page 2 then page 1 before vsync -> disp_page stays 0 until the vsync rise, then 1 with a single flip_done. Following scan read uses mem_addr[15:14]=01.
- flip_req coincident with vsync rise (no prior pending) -> no change at that edge; disp_page updates at the next vsync rise.
- Assert reset with 2 reads in flight -> no rvalid afterwards; pending flip cleared; disp_page=0.
